// File: rtl/int_ctrl_if.sv
// Request/acknowledge bundle between the Gumnut core and int_ctrl.
// The core side drives the master modport; int_ctrl takes the slave modport.
`timescale 1ns/1ps
interface int_ctrl_if #(
  parameter int N_SRC = 4,
  parameter int VEC_W = 12,
  parameter int IDW   = (N_SRC > 1) ? $clog2(N_SRC) : 1
);
  logic [N_SRC-1:0] irq_i;
  logic             int_en_i;
  logic             imask_we_i;
  logic [N_SRC-1:0] imask_i;
  logic             int_ack_i;
  logic             reti_i;
  logic             int_req_o;
  logic             save_we_o;
  logic [VEC_W-1:0] vec_o;
  logic [IDW-1:0]   src_id_o;
  logic             in_service_o;
  logic [N_SRC-1:0] pend_o;

  modport master (
    output irq_i, int_en_i, imask_we_i,
    output imask_i, int_ack_i, reti_i,
    input  int_req_o, save_we_o, vec_o,
    input  src_id_o, in_service_o, pend_o
  );

  modport slave (
    input  irq_i, int_en_i, imask_we_i,
    input  imask_i, int_ack_i, reti_i,
    output int_req_o, save_we_o, vec_o,
    output src_id_o, in_service_o, pend_o
  );
endinterface

// File: rtl/int_ctrl.sv
// Edge-capturing, masked, fixed-priority interrupt controller that
// sequences the Gumnut interrupt-save register; one handler at a time.
`timescale 1ns/1ps
module int_ctrl #(
  parameter int             N_SRC      = 4,
  parameter int             VEC_W      = 12,
  parameter logic [VEC_W-1:0] VEC_BASE   = 12'h001,
  parameter logic [VEC_W-1:0] VEC_STRIDE = 12'h004,
  localparam int            IDW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cen,
  int_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    SAVE,
    SERV
  } state_e;

  state_e           state_q;
  logic [N_SRC-1:0] pend_q;
  logic [N_SRC-1:0] pend_d;
  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] irq_prev_q;
  logic [IDW-1:0]   src_id_q;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] clr;
  logic [IDW-1:0]   win;

  always_comb begin
    rise = bus.irq_i & ~irq_prev_q;
    cand = pend_q & mask_q;
    win  = '0;
    clr  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i]) win = IDW'(i);
      clr[i] = (state_q == SAVE) &&
               (src_id_q == IDW'(i));
    end
    // a fresh edge on the bit being retired keeps it pending
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      mask_q     <= '0;
      irq_prev_q <= '0;
      src_id_q   <= '0;
    end else if (cen) begin
      irq_prev_q <= bus.irq_i;
      pend_q     <= pend_d;
      if (bus.imask_we_i) mask_q <= bus.imask_i;
      unique case (state_q)
        IDLE: begin
          if (bus.int_en_i && |cand) begin
            src_id_q <= win;
            state_q  <= PEND;
          end
        end
        PEND: begin
          if (bus.int_ack_i) state_q <= SAVE;
          else if (!bus.int_en_i) state_q <= IDLE;
        end
        SAVE: state_q <= SERV;
        SERV: begin
          if (bus.reti_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.int_req_o    = (state_q == PEND);
  assign bus.save_we_o    = (state_q == SAVE);
  assign bus.in_service_o = (state_q == SERV);
  assign bus.src_id_o     = src_id_q;
  assign bus.pend_o       = pend_q;
  assign bus.vec_o        = VEC_BASE +
                            VEC_W'(src_id_q) * VEC_STRIDE;

endmodule
